// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO: the head word sits on o_fifo_data
// whenever o_fifo_not_empty is high. It keeps registered flags and sticky error flags.
module sync_fwft_fifo #(
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 4,
    parameter int ALMOST_FULL_LEVEL = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic [DATA_WIDTH-1:0] i_fifo_w_data,
    input  logic                  i_fifo_w_stb,
    output logic                  o_fifo_full,
    output logic                  o_fifo_almost_full,
    output logic [DATA_WIDTH-1:0] o_fifo_data,
    output logic                  o_fifo_not_empty,
    input  logic                  i_fifo_r_stb,
    output logic [ADDR_WIDTH:0]   o_fifo_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic                  r_almost_full;
    logic                  r_not_empty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic [ADDR_WIDTH:0]   w_count_next;

    // Acceptance looks only at this cycle's registered flags; no full/empty bypass.
    assign w_wr_accept = i_fifo_w_stb & ~r_full;
    assign w_rd_accept = i_fifo_r_stb & r_not_empty;

    always_comb begin
        w_count_next = r_count;
        if (i_clear) begin
            w_count_next = '0;
        end else if (w_wr_accept && !w_rd_accept) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_wr_accept && w_rd_accept) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_not_empty   <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            if (i_clear) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                if (w_wr_accept) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_rd_accept) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (i_fifo_w_stb && r_full) begin
                    r_overflow <= 1'b1;
                end
                if (i_fifo_r_stb && !r_not_empty) begin
                    r_underflow <= 1'b1;
                end
            end
            r_count       <= w_count_next;
            r_full        <= (w_count_next == DEPTH_CNT);
            r_almost_full <= (w_count_next >= AF_CNT);
            r_not_empty   <= (w_count_next != '0);
        end
    end

    // Storage is deliberately left out of reset so it can map onto distributed RAM.
    always_ff @(posedge i_clk) begin
        if (w_wr_accept && !i_clear) begin
            r_mem[r_wr_ptr] <= i_fifo_w_data;
        end
    end

    assign o_fifo_data        = r_mem[r_rd_ptr];
    assign o_fifo_full        = r_full;
    assign o_fifo_almost_full = r_almost_full;
    assign o_fifo_not_empty   = r_not_empty;
    assign o_fifo_count       = r_count;
    assign o_overflow         = r_overflow;
    assign o_underflow        = r_underflow;

endmodule
